// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO with fill count, almost-full/almost-empty thresholds,
// sticky error flags, synchronous flush and optional first-word-fall-through reads.
module fifo_sync_ctrl #(
    parameter int dw     = 32,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = 14,
    parameter int AE_LVL = 2,
    parameter int FWFT   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic [dw-1:0]              din,
    input  logic                       wen,
    input  logic                       ren,
    output logic [dw-1:0]              dout,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [dw-1:0] mem [DEPTH];
    logic [CW-1:0] wr_ptr, rd_ptr, count_q;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          wr_ok, rd_ok;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // Equal indices with differing wrap bits means the writer is a full lap ahead.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

    assign almost_full  = (count_q >= CW'(AF_LVL));
    assign almost_empty = (count_q <= CW'(AE_LVL));
    assign count        = count_q;

    assign rd_ok = ren & ~empty;
    assign wr_ok = wen & (~full | rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok && !clr)
            mem[wr_idx] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + CW'(1);
            if (rd_ok)
                rd_ptr <= rd_ptr + CW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (wen && !wr_ok)
                overflow <= 1'b1;
            if (ren && !rd_ok)
                underflow <= 1'b1;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = empty ? '0 : mem[rd_idx];
        end else begin : g_std
            logic [dw-1:0] dout_q;

            // Flush leaves the last read word in place; only reset clears it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    dout_q <= '0;
                else if (rd_ok && !clr)
                    dout_q <= mem[rd_idx];
            end

            assign dout = dout_q;
        end
    endgenerate

endmodule
